// File: rtl/axis_chk_pkg.sv
// Shared constants for the AXI-Stream test-packet checker.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
// Contents: error codes, FSM state encoding, LFSR seed/taps and step function.
package axis_chk_pkg;

  typedef enum logic [1:0] {
    HDR   = 2'd0,
    BODY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_HDR   = 3'd1;
  localparam logic [2:0] ERR_DATA  = 3'd2;
  localparam logic [2:0] ERR_SHORT = 3'd3;
  localparam logic [2:0] ERR_LONG  = 3'd4;
  localparam logic [2:0] ERR_KEEP  = 3'd5;
  localparam logic [2:0] ERR_USER  = 3'd6;

  // Fibonacci taps 16,15,13,4 map to bits 15,14,12,3 of the state.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hD008;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/axis_pkt_checker_if.sv
// AXI-Stream bundle between a packet source and the checker sink.
// Latency: n/a (wires only).
// Backpressure: tready flows from slave to master.
// Signals: tvalid/tdata/tlast/tkeep/tuser (master->slave), tready (slave->master).
interface axis_pkt_checker_if #(
  parameter int P_DATA_W = 64,
  parameter int P_KEEP_W = 8
);
  logic                tvalid;
  logic [P_DATA_W-1:0] tdata;
  logic                tlast;
  logic [P_KEEP_W-1:0] tkeep;
  logic                tuser;
  logic                tready;

  modport master (output tvalid, tdata, tlast, tkeep, tuser, input tready);
  modport slave  (input tvalid, tdata, tlast, tkeep, tuser, output tready);
endinterface

// File: rtl/axis_chk_ready_gen.sv
// tready generator for the packet checker: enable gating plus a one-cycle stall.
// Latency: stall appears the cycle after the beat at P_STALL_IDX is accepted.
// Backpressure: tready = enable & ~stall; held low while rst is asserted.
// Ports: clk, rst, i_enable, i_acc (beat accepted), i_beat_idx, o_tready.
// Macro AXIS_CHK_LFSR_STALL_EN adds ~1/8 pseudo-random stall from a 16-bit LFSR.
module axis_chk_ready_gen
  import axis_chk_pkg::*;
#(
  parameter int P_PKT_LEN   = 16,
  parameter int P_STALL_IDX = 14,
  parameter int P_IDX_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_enable,
  input  logic               i_acc,
  input  logic [P_IDX_W-1:0] i_beat_idx,
  output logic               o_tready
);

  // An index beyond the packet length can never be reached, so it disables the stall.
  localparam bit STALL_EN = (P_STALL_IDX < P_PKT_LEN);

  logic r_stall;
  logic w_hit;
  logic w_stall;

  assign w_hit = STALL_EN && (i_beat_idx == P_IDX_W'(P_STALL_IDX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall <= 1'b0;
    end else begin
      r_stall <= i_acc & w_hit;
    end
  end

`ifdef AXIS_CHK_LFSR_STALL_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign w_stall = r_stall | (r_lfsr[2:0] == 3'b000);
`else
  assign w_stall = r_stall;
`endif

  // Gated by rst so the sink presents tready = 0 while in reset.
  assign o_tready = i_enable & ~w_stall & ~rst;

endmodule

// File: rtl/axis_pkt_checker.sv
// AXI-Stream sink that checks the standard test-packet format and keeps statistics.
// Latency: completion results (done/src/counters/code) register 1 cycle after tlast accept.
// Backpressure: tready from axis_chk_ready_gen; dropping i_enable stalls, never aborts.
// Ports: clk, rst (async, active-high), i_enable, i_clr, s_axis (slave modport),
//        o_pkt_cnt, o_err_cnt, o_err_flag, o_err_code, o_last_src, o_pkt_done.
// Optional macro AXIS_CHK_LFSR_STALL_EN (random stall) is handled in axis_chk_ready_gen.
module axis_pkt_checker
  import axis_chk_pkg::*;
#(
  parameter int P_DATA_W    = 64,
  parameter int P_KEEP_W    = 8,
  parameter int P_PKT_LEN   = 16,
  parameter int P_NUM_SRC   = 4,
  parameter int P_STALL_IDX = 14,
  parameter int P_CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_enable,
  input  logic               i_clr,
  axis_pkt_checker_if.slave  s_axis,
  output logic [P_CNT_W-1:0] o_pkt_cnt,
  output logic [P_CNT_W-1:0] o_err_cnt,
  output logic               o_err_flag,
  output logic [2:0]         o_err_code,
  output logic [7:0]         o_last_src,
  output logic               o_pkt_done
);

  localparam int                 IDX_W    = $clog2(P_PKT_LEN);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(P_PKT_LEN - 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_beat_idx;
  logic [2:0]         r_code;
  logic [7:0]         r_src;
  logic [P_CNT_W-1:0] r_pkt_cnt;
  logic [P_CNT_W-1:0] r_err_cnt;
  logic               r_err_flag;
  logic [2:0]         r_err_code;
  logic [7:0]         r_last_src;
  logic               r_pkt_done;

  logic       w_tready;
  logic       w_acc;
  logic       w_done;
  logic       w_keep_bad;
  logic       w_hdr_bad;
  logic       w_data_bad;
  logic [2:0] w_beat_code;
  logic [2:0] w_pkt_code;
  logic [7:0] w_src;

  axis_chk_ready_gen #(
    .P_PKT_LEN   (P_PKT_LEN),
    .P_STALL_IDX (P_STALL_IDX),
    .P_IDX_W     (IDX_W)
  ) u_ready_gen (
    .clk        (clk),
    .rst        (rst),
    .i_enable   (i_enable),
    .i_acc      (w_acc),
    .i_beat_idx (r_beat_idx),
    .o_tready   (w_tready)
  );

  assign s_axis.tready = w_tready;
  assign w_acc         = s_axis.tvalid & w_tready;
  assign w_done        = w_acc & s_axis.tlast;

  // Last beat may be partial but must carry at least one byte.
  assign w_keep_bad = s_axis.tlast ? (s_axis.tkeep == '0) : (s_axis.tkeep != '1);
  assign w_hdr_bad  = (s_axis.tdata[7:0] == 8'd0) || (s_axis.tdata[7:0] > 8'(P_NUM_SRC));
  assign w_data_bad = (s_axis.tdata != P_DATA_W'(r_beat_idx));

  // Error found on the current beat; within one beat content errors outrank framing.
  always_comb begin
    w_beat_code = ERR_NONE;
    case (r_state)
      HDR: begin
        if (w_hdr_bad)         w_beat_code = ERR_HDR;
        else if (w_keep_bad)   w_beat_code = ERR_KEEP;
        else if (s_axis.tuser) w_beat_code = ERR_USER;
        else if (s_axis.tlast) w_beat_code = ERR_SHORT;
      end
      BODY: begin
        if (w_data_bad)        w_beat_code = ERR_DATA;
        else if (w_keep_bad)   w_beat_code = ERR_KEEP;
        else if (s_axis.tuser) w_beat_code = ERR_USER;
        else if (s_axis.tlast && (r_beat_idx != LAST_IDX))
          w_beat_code = ERR_SHORT;
        else if (!s_axis.tlast && (r_beat_idx == LAST_IDX))
          w_beat_code = ERR_LONG;
      end
      default: w_beat_code = ERR_NONE;
    endcase
  end

  // First error of the packet sticks; the header beat starts a fresh record.
  assign w_pkt_code = ((r_state == HDR) || (r_code == ERR_NONE)) ? w_beat_code : r_code;
  assign w_src      = (r_state == HDR) ? s_axis.tdata[7:0] : r_src;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= HDR;
      r_beat_idx <= '0;
      r_code     <= ERR_NONE;
      r_src      <= '0;
      r_pkt_cnt  <= '0;
      r_err_cnt  <= '0;
      r_err_flag <= 1'b0;
      r_err_code <= ERR_NONE;
      r_last_src <= '0;
      r_pkt_done <= 1'b0;
    end else begin
      r_pkt_done <= 1'b0;

      if (w_acc) begin
        r_code <= w_pkt_code;
        case (r_state)
          HDR: begin
            r_src <= s_axis.tdata[7:0];
            if (!s_axis.tlast) begin
              r_beat_idx <= IDX_W'(1);
              r_state    <= BODY;
            end
          end
          BODY: begin
            if (s_axis.tlast) begin
              r_beat_idx <= '0;
              r_state    <= HDR;
            end else if (r_beat_idx == LAST_IDX) begin
              r_state <= DRAIN;
            end else begin
              r_beat_idx <= r_beat_idx + IDX_W'(1);
            end
          end
          DRAIN: begin
            // beat_idx stays at LAST_IDX while surplus beats are discarded.
            if (s_axis.tlast) begin
              r_beat_idx <= '0;
              r_state    <= HDR;
            end
          end
          default: begin
            r_beat_idx <= '0;
            r_state    <= HDR;
          end
        endcase
      end

      if (w_done) begin
        r_pkt_done <= 1'b1;
        r_last_src <= w_src;
      end

      // Clear takes priority over a coincident completion's statistics update.
      if (i_clr) begin
        r_pkt_cnt  <= '0;
        r_err_cnt  <= '0;
        r_err_flag <= 1'b0;
        r_err_code <= ERR_NONE;
      end else if (w_done) begin
        if (w_pkt_code == ERR_NONE) begin
          if (r_pkt_cnt != '1) r_pkt_cnt <= r_pkt_cnt + P_CNT_W'(1);
        end else begin
          if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + P_CNT_W'(1);
          r_err_code <= w_pkt_code;
          r_err_flag <= 1'b1;
        end
      end
    end
  end

  assign o_pkt_cnt  = r_pkt_cnt;
  assign o_err_cnt  = r_err_cnt;
  assign o_err_flag = r_err_flag;
  assign o_err_code = r_err_code;
  assign o_last_src = r_last_src;
  assign o_pkt_done = r_pkt_done;

endmodule

// File: doc/axis_pkt_checker.md
Name: axis_pkt_checker

Overview:
- AXI-Stream sink that terminates one crossbar master port (m*_axis_tx_*) and checks every received packet against the team's standard test-packet format.
- Format: 16 beats; beat 0 carries the source id (1..4); beat k carries k for k = 1..15; tkeep is all-ones except on the last beat.
- Drives tready with a deterministic backpressure pattern, counts good and bad packets, and records the first error per packet.
- Used in system benches and on-chip self-test in place of hand-written tb sinks.

Parameters:
- P_DATA_W, 64, tdata width.
- P_KEEP_W, 8, tkeep width (P_DATA_W/8).
- P_PKT_LEN, 16, required beats per packet (>=2).
- P_NUM_SRC, 4, valid header ids are 1..P_NUM_SRC.
- P_STALL_IDX, 14, beat index after whose acceptance tready drops for exactly one cycle; a value >= P_PKT_LEN disables the stall.
- P_CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- i_enable  in  1  sink enable; when low, tready is held low
- i_clr  in  1  synchronous clear of counters and sticky flag
- s_axis_tvalid  in  1  beat valid
- s_axis_tdata  in  P_DATA_W  beat data
- s_axis_tlast  in  1  last beat of packet
- s_axis_tkeep  in  P_KEEP_W  byte enables
- s_axis_tuser  in  1  upstream error marker
- s_axis_tready  out  1  sink ready
- o_pkt_cnt  out  P_CNT_W  good packets, saturating
- o_err_cnt  out  P_CNT_W  bad packets, saturating
- o_err_flag  out  1  sticky; set on any bad packet
- o_err_code  out  3  first error of the most recent bad packet
- o_last_src  out  8  header id of the most recently completed packet (tdata[7:0] of beat 0)
- o_pkt_done  out  1  one-cycle pulse at packet completion, good or bad

Behaviour:
- Reset values: all outputs are 0, the FSM is in HDR, and beat_idx is 0.
- Beat accept: acc = tvalid & tready.
- tready = i_enable & ~stall. stall is a register set for one cycle on the cycle after acc with beat_idx == P_STALL_IDX. Dropping i_enable mid-packet only stalls the packet; it never aborts it.
- FSM states:
  - HDR: on acc, check the header, latch the source id, set beat_idx = 1, and go to BODY. If tlast is set, record a short error and complete.
  - BODY: on acc, check tdata == beat_idx (zero-extended) and check tkeep. Then:
    - tlast with beat_idx < P_PKT_LEN-1: SHORT error, complete, go to HDR.
    - tlast with beat_idx == P_PKT_LEN-1: complete, go to HDR.
    - no tlast with beat_idx == P_PKT_LEN-1: LONG error, go to DRAIN.
    - otherwise increment beat_idx.
  - DRAIN: accept and ignore beats until acc & tlast, then complete and go to HDR. beat_idx saturates at P_PKT_LEN-1.
- Error codes, first one per packet kept, later ones in the same packet ignored:
  - 0 NONE
  - 1 HDR: id is 0 or > P_NUM_SRC
  - 2 DATA
  - 3 SHORT
  - 4 LONG
  - 5 KEEP: tkeep != all-ones on a non-last beat, or tkeep == 0 on the last beat
  - 6 USER: tuser = 1 on any beat
- Completion, registered, takes effect the cycle after the tlast acceptance:
  - o_pkt_done pulses.
  - o_last_src updates.
  - If the packet is good, o_pkt_cnt++. Otherwise o_err_cnt++, o_err_code is set to the recorded code, and o_err_flag is set.
  - Both counters saturate at all-ones.
- i_clr clears the counters, o_err_flag and o_err_code. It does not touch the FSM. If i_clr coincides with a completion, the clear wins and the increment is dropped.
- Reset mid-packet returns the FSM to HDR, so the remainder of the interrupted packet is checked as a new packet.

Optional Feature:
- AXIS_CHK_LFSR_STALL_EN
  - Defined: stall additionally asserts when a free-running 16-bit Fibonacci LFSR (taps 16,15,13,4; seed 16'hACE1 on reset) has bits[2:0] == 0, giving roughly 1/8 random backpressure.
  - Undefined: only the deterministic P_STALL_IDX stall exists, and no LFSR logic is generated.

Decomposition:
- Package axis_chk_pkg holds:
  - the error-code constants (ERR_NONE..ERR_USER, 3 bits);
  - the FSM state constants HDR/BODY/DRAIN;
  - the LFSR seed and taps.
- Sub-module axis_chk_ready_gen produces tready from i_enable, acc, beat_idx and the optional LFSR. It is the only module affected by the macro.
- The checker FSM and counters stay in the top module.

Test Plan:
1. Four good packets with ids 1, 2, 3, 4, last tkeep 8'hf0, tvalid held high → o_pkt_cnt = 4, o_err_cnt = 0, o_last_src = 4, tready low for exactly one cycle after beat 14 of each packet, and no beat lost or duplicated.
2. Packet with header id 5 → o_err_code = 1, o_err_cnt = 1, o_err_flag = 1; a following good packet gives o_pkt_cnt = 1 and o_err_flag stays 1.
3. Packet with tlast on beat 9 → code 3 and o_pkt_done one cycle after beat 9. Separately, a 20-beat packet → code 4, and completion occurs only at beat 19's tlast.
4. Packet with beat 6 data = 7 and tuser = 1 on beat 10 → code 2 (first error wins), err_cnt += 1.
5. Assert rst at beat 8, then resend a good packet → all outputs 0 during reset, then o_pkt_cnt = 1. Drop i_enable for 5 cycles mid-packet → packet still good.
6. With AXIS_CHK_LFSR_STALL_EN, 100 random-length-good packets → o_pkt_cnt = 100, the tready duty cycle is roughly 0.85, and the tready pattern is identical across two runs with the same seed.
